// File: rtl/alu_dispatcher.sv
// alu_dispatcher: RV32I ALU issue unit, IDLE->DECODE->EXEC->WB; define ALU_DISPATCHER_DBG_PORT_EN to expose rf reads on dbg_data
module alu_dispatcher #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [1:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  output logic            done,
  output logic            illegal,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ILL} state_t;
  state_t state;
  logic [31:0] ir;
  logic [XLEN-1:0] rf [NUM_REGS];
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic r_type, i_type, legal;
  logic [1:0] ctrl;
  logic [XLEN-1:0] a, b;
  assign {f7, rs2, rs1, f3, rd, op} = ir;
  assign r_type = op == 7'b0110011;
  assign i_type = op == 7'b0010011;
  assign legal = ((r_type && f7 == 7'b0000000) || i_type) && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b100)
              || (r_type || i_type) && f3 == 3'b101 && f7 == 7'b0100000;
  assign ctrl = f3 == 3'b000 ? 2'b00 : f3 == 3'b101 ? 2'b01 : f3 == 3'b111 ? 2'b10 : 2'b11;
  assign a = rf[rs1];
  assign b = r_type ? rf[rs2] : f3 == 3'b101 ? {{(XLEN-5){1'b0}}, rs2} : {{(XLEN-12){f7[6]}}, f7, rs2};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir <= '0;
      instr_ready <= 1'b1;
      alu_a <= '0;
      alu_b <= '0;
      alu_control <= 2'b00;
      done <= 1'b0;
      illegal <= 1'b0;
      wb_rd <= 5'd0;
      wb_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          ir <= instr;
          instr_ready <= 1'b0;
          state <= DECODE;
        end
        DECODE: begin
          if (legal) begin
            alu_a <= a;
            alu_b <= b;
            alu_control <= ctrl;
          end
          illegal <= !legal;
          state <= legal ? EXEC : ILL;
        end
        EXEC: begin
          done <= 1'b1;
          wb_rd <= rd;
          wb_data <= rd == 5'd0 ? '0 : alu_result;
          state <= WB;
        end
        WB: begin
          if (wb_rd != 5'd0) rf[wb_rd] <= wb_data;
          done <= 1'b0;
          instr_ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          illegal <= 1'b0;
          instr_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef ALU_DISPATCHER_DBG_PORT_EN
  assign dbg_data = rf[dbg_addr];
`else
  logic unused_dbg;
  assign unused_dbg = ^dbg_addr;
  assign dbg_data = '0;
`endif
endmodule

// File: tb/tb_alu_dispatcher.sv
// tb_alu_dispatcher: random and directed RV32I stimulus against a schedule-based reference model
module tb_alu_dispatcher;
  logic clk = 0, rst = 1, instr_valid = 0;
  logic [31:0] instr = 0;
  logic [4:0] dbg_addr = 0;
  logic instr_ready, done, illegal;
  logic [31:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [1:0] alu_control;
  logic [4:0] wb_rd;
  int checks = 0, fails = 0, e = 0, acc_cnt = 0;
  int done_at = -1, ill_at = -1, dec_at = -1, ret_at = -1;
  bit m_ready = 1, ok;
  logic [31:0] mrf [32];
  logic [31:0] m_a = 0, m_b = 0, p_a, p_b, p_data, bv;
  logic [1:0] m_c = 0, p_c, c;
  logic [4:0] p_rd;
  logic [6:0] op, f7;
  logic [2:0] f3;
  always #5 clk = ~clk;
  function automatic logic [31:0] alu(input logic [1:0] k, input logic [31:0] x, input logic [31:0] y);
    case (k)
      2'd0: return x + y;
      2'd1: return $unsigned($signed(x) >>> y[4:0]);
      2'd2: return x & y;
      default: return x ^ y;
    endcase
  endfunction
  assign alu_result = alu(alu_control, alu_a, alu_b);
  alu_dispatcher dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .done(done), .illegal(illegal), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h at edge %0d", name, act, exp, e);
    end
  endtask
  always @(posedge clk) begin
    e++;
    if (rst) begin
      m_ready = 1;
      done_at = -1;
      ill_at = -1;
      dec_at = -1;
      ret_at = -1;
      m_a = 0;
      m_b = 0;
      m_c = 0;
      foreach (mrf[i]) mrf[i] = 0;
    end else if (m_ready && instr_valid) begin
      op = instr[6:0];
      f3 = instr[14:12];
      f7 = instr[31:25];
      c = f3 == 3'd0 ? 2'd0 : f3 == 3'd5 ? 2'd1 : f3 == 3'd7 ? 2'd2 : 2'd3;
      ok = (op == 7'h33 || op == 7'h13) && (f3 == 3'd5 ? f7 == 7'h20 : (f3 inside {3'd0, 3'd4, 3'd7}) && (op == 7'h13 || f7 == 7'h00));
      bv = op == 7'h33 ? mrf[instr[24:20]] : f3 == 3'd5 ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
      acc_cnt++;
      m_ready = 0;
      if (ok) begin
        p_a = mrf[instr[19:15]];
        p_b = bv;
        p_c = c;
        p_rd = instr[11:7];
        p_data = p_rd == 0 ? 0 : alu(c, p_a, bv);
        dec_at = e + 1;
        done_at = e + 2;
        ret_at = e + 3;
      end else begin
        p_rd = 0;
        ill_at = e + 1;
        ret_at = e + 2;
      end
    end else begin
      if (e == dec_at) begin
        m_a = p_a;
        m_b = p_b;
        m_c = p_c;
      end
      if (e == ret_at) begin
        m_ready = 1;
        if (p_rd != 0) mrf[p_rd] = p_data;
      end
    end
  end
  always @(negedge clk) if (e > 0) begin
    chk("ready", instr_ready, m_ready);
    chk("done", done, e == done_at);
    chk("illegal", illegal, e == ill_at);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_control", alu_control, m_c);
    if (e == done_at) begin
      chk("wb_rd", wb_rd, p_rd);
      chk("wb_data", wb_data, p_data);
    end
`ifdef ALU_DISPATCHER_DBG_PORT_EN
    chk("dbg", dbg_data, mrf[dbg_addr]);
`else
    chk("dbg", dbg_data, 0);
`endif
    dbg_addr = 5'($urandom);
  end
  function automatic logic [31:0] r_enc(input logic [6:0] fn7, input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] fn3, input logic [4:0] d);
    return {fn7, s2, s1, fn3, d, 7'h33};
  endfunction
  function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [4:0] s1, input logic [2:0] fn3, input logic [4:0] d);
    return {imm, s1, fn3, d, 7'h13};
  endfunction
  task automatic issue(input logic [31:0] w);
    int n;
    n = acc_cnt;
    instr = w;
    instr_valid = 1;
    for (int k = 0; k < 20 && acc_cnt == n; k++) @(negedge clk);
    instr_valid = 0;
    if (acc_cnt == n) chk("accept_timeout", 0, 1);
  endtask
  task automatic retire(input logic [4:0] rd, input logic [31:0] data);
    repeat (2) @(negedge clk);
    chk("lat_done", done, 1);
    chk("lit_rd", wb_rd, rd);
    chk("lit_data", wb_data, data);
  endtask
  task automatic load(input logic [4:0] rd, input logic [31:0] v);
    issue(i_enc(12'd0, 5'd0, 3'd0, rd));
    for (int i = 31; i >= 0; i--) begin
      issue(r_enc(7'h00, rd, rd, 3'd0, rd));
      if (v[i]) issue(i_enc(12'd1, rd, 3'd0, rd));
    end
  endtask
  initial begin
    int s;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_control", alu_control, 0);
    issue(32'hFFB00093);
    retire(5'd1, 32'hFFFFFFFB);
    chk("addi_ctrl", alu_control, 0);
    load(5'd1, 32'h80000000);
    issue(i_enc(12'h404, 5'd1, 3'd5, 5'd2));
    retire(5'd2, 32'hF8000000);
    chk("srai_ctrl", alu_control, 1);
    chk("srai_b", alu_b, 4);
    load(5'd1, 32'hF0F0F0F0);
    load(5'd3, 32'h0FF00FF0);
    issue(r_enc(7'h00, 5'd3, 5'd1, 3'd7, 5'd4));
    retire(5'd4, 32'h00F000F0);
    issue(r_enc(7'h00, 5'd3, 5'd1, 3'd4, 5'd5));
    retire(5'd5, 32'hFF00FF00);
    issue(r_enc(7'h00, 5'd5, 5'd4, 3'd4, 5'd6));
    retire(5'd6, 32'hFFF0FFF0);
    issue(i_enc(12'd7, 5'd0, 3'd0, 5'd0));
    retire(5'd0, 32'd0);
    @(posedge clk);
    dbg_addr = 0;
    #1 chk("dbg_x0", dbg_data, 0);
    issue(r_enc(7'h20, 5'd3, 5'd2, 3'd0, 5'd1));
    @(negedge clk);
    chk("sub_illegal", illegal, 1);
    chk("sub_no_done", done, 0);
    issue({12'd0, 5'd2, 3'd2, 5'd1, 7'b0000011});
    @(negedge clk);
    chk("load_illegal", illegal, 1);
    @(negedge clk);
    chk("illegal_once", illegal, 0);
    issue(i_enc(12'd0, 5'd1, 3'd0, 5'd7));
    retire(5'd7, 32'hF0F0F0F0);
    issue(i_enc(12'd1, 5'd0, 3'd0, 5'd6));
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);
    chk("post_rst_done", done, 0);
    issue(i_enc(12'd0, 5'd6, 3'd0, 5'd7));
    retire(5'd7, 32'd0);
    for (int k = 0; k < 300; k++) begin
      s = $urandom_range(0, 9);
      op = s < 4 ? 7'h33 : s < 8 ? 7'h13 : 7'($urandom);
      s = $urandom_range(0, 3);
      f7 = s < 2 ? 7'h00 : s == 2 ? 7'h20 : 7'($urandom);
      issue({f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
